// File: rtl/ds_pkg.sv
// ds_pkg: shared definitions for the 2x2 down-sample average sequencer.
//   - ALU opcode constants driven on alu_control
//   - sequencer state encoding
//   - number of pixel taps per average
package ds_pkg;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_MUL     = 4'd2;
  localparam logic [3:0] ALU_DIV     = 4'd3;
  localparam logic [3:0] ALU_AND     = 4'd4;
  localparam logic [3:0] ALU_OR      = 4'd5;
  localparam logic [3:0] ALU_NOT     = 4'd6;
  localparam logic [3:0] ALU_INC     = 4'd7;
  localparam logic [3:0] ALU_DEC     = 4'd8;
  localparam logic [3:0] ALU_LSHIFT8 = 4'd9;
  localparam logic [3:0] ALU_ATOC    = 4'd10;
  localparam logic [3:0] ALU_BTOC    = 4'd11;

  localparam int unsigned DS_TAPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } ds_state_e;

endpackage

// File: rtl/ds_line_counter.sv
// ds_line_counter: wrapping output counter for line boundaries.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (start of a new frame)
//   inc_i      : count one output; wraps to 0 after LINE_LEN-1
//   last_o     : current count is the last position of a line
module ds_line_counter #(
  parameter int unsigned LINE_LEN = 320,
  parameter int unsigned CNT_W    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;

  assign last_o = (cnt_q == CNT_W'(LINE_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ds_avg_sequencer.sv
// ds_avg_sequencer: drives a shared combinational ALU to average every four
// pixel words (load, 3x add, divide-by-4) and emits one result per group.
//   flush                         : sync abort, clears partial sums and line count
//   in_valid/in_ready/in_data     : pixel input stream
//   out_valid/out_ready/out_data  : average output stream, out_last ends a line
//   alu_control/alu_a/alu_b       : ALU drive, alu_c is its same-cycle result
module ds_avg_sequencer
  import ds_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LINE_LEN = 320,
  parameter int unsigned LCNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c
);

  localparam int unsigned         TAP_W    = $clog2(DS_TAPS);
  localparam logic [TAP_W-1:0]    TAP_LAST = TAP_W'(DS_TAPS - 1);

  ds_state_e        state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] res_q;
  logic [TAP_W-1:0] tap_cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;

  logic             hs;
  logic             line_inc;
  logic             line_last;

  // flush wins over a same-cycle handshake, so the word is not taken.
  assign hs       = in_valid & in_ready_q & ~flush;
  assign line_inc = (state_q == ST_OUT) & out_ready & ~flush;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign out_last  = out_last_q;

  ds_line_counter #(
    .LINE_LEN (LINE_LEN),
    .CNT_W    (LCNT_W)
  ) u_line_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush),
    .inc_i  (line_inc),
    .last_o (line_last)
  );

  // ALU drive is combinational because the result is captured in the same
  // cycle as the handshake; idle cycles park it on AtoC.
  always_comb begin
    alu_control = ALU_ATOC;
    alu_a       = acc_q;
    alu_b       = '0;
    unique case (state_q)
      ST_IDLE: if (hs) begin
        alu_control = ALU_BTOC;
        alu_b       = in_data;
      end
      ST_ACC: if (hs) begin
        alu_control = ALU_ADD;
        alu_b       = in_data;
      end
      ST_DIV:  alu_control = ALU_DIV;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      res_q       <= '0;
      tap_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (hs) begin
            acc_q     <= alu_c;
            tap_cnt_q <= TAP_W'(1);
            state_q   <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (hs) begin
            acc_q     <= alu_c;
            tap_cnt_q <= tap_cnt_q + TAP_W'(1);
            if (tap_cnt_q == TAP_LAST) begin
              state_q    <= ST_DIV;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DIV: begin
          res_q       <= alu_c;
          out_valid_q <= 1'b1;
          out_last_q  <= line_last;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_avg_sequencer.sv
module tb_ds_avg_sequencer;

  localparam int LL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_data, alu_a, alu_b, alu_c;
  logic [3:0]  alu_control;

  int checks = 0;
  int errors = 0;

  ds_avg_sequencer #(
    .WIDTH    (16),
    .LINE_LEN (LL),
    .LCNT_W   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c)
  );

  always #5 clk = ~clk;

  // Shared ALU behaviour.
  always_comb begin
    case (alu_control)
      4'd0:    alu_c = alu_a + alu_b;
      4'd1:    alu_c = alu_a - alu_b;
      4'd2:    alu_c = alu_a * alu_b;
      4'd3:    alu_c = alu_a >> 2;
      4'd4:    alu_c = alu_a & alu_b;
      4'd5:    alu_c = alu_a | alu_b;
      4'd6:    alu_c = ~alu_a;
      4'd7:    alu_c = alu_a + 16'd1;
      4'd8:    alu_c = alu_a - 16'd1;
      4'd9:    alu_c = alu_a << 8;
      4'd10:   alu_c = alu_a;
      4'd11:   alu_c = alu_b;
      default: alu_c = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: pixel groups of four, average = wrapped sum / 4,
  // one output at a time, line position counted modulo LL.
  int          px_q[$];
  logic [15:0] m_sum;
  bit          m_div, m_out, m_rdy, m_ol;
  logic [15:0] m_od;
  int          m_line;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [15:0] obs_d[$];
  bit          obs_l[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q.delete();
      m_sum  = '0;
      m_div  = 0;
      m_out  = 0;
      m_rdy  = 0;
      m_line = 0;
    end else begin
      if (m_div) begin
        chk("alu_div_op", alu_control, 4'd3);
        chk("alu_div_a", alu_a, m_sum);
      end else if (m_rdy && in_valid && !flush) begin
        chk("alu_acc_op", alu_control, (px_q.size() == 0) ? 4'd11 : 4'd0);
        chk("alu_acc_b", alu_b, in_data);
        if (px_q.size() != 0) chk("alu_acc_a", alu_a, m_sum);
      end else begin
        chk("alu_park_op", alu_control, 4'd10);
        chk("alu_park_b", alu_b, 16'd0);
      end
      if (m_out && out_ready && !flush) begin
        obs_d.push_back(out_data);
        obs_l.push_back(out_last);
      end
      if (flush) begin
        px_q.delete();
        m_sum  = '0;
        m_div  = 0;
        m_out  = 0;
        m_line = 0;
      end else if (m_div) begin
        m_div = 0;
        m_out = 1;
        m_od  = m_sum >> 2;
        m_ol  = (m_line == LL - 1);
      end else if (m_out) begin
        if (out_ready) begin
          m_out  = 0;
          m_line = (m_line + 1) % LL;
        end
      end else if (m_rdy && in_valid) begin
        px_q.push_back(int'(in_data));
        m_sum = '0;
        foreach (px_q[i]) m_sum = m_sum + 16'(px_q[i]);
        if (px_q.size() == 4) begin
          m_div = 1;
          px_q.delete();
          acc_cyc = cyc;
        end
      end
      m_rdy = !(m_div || m_out);
      cyc++;
    end
  end

  bit prev_ov = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_out);
      if (m_out) begin
        chk("out_data", out_data, m_od);
        chk("out_last", out_last, m_ol);
        if (!prev_ov) chk("out_latency", cyc - acc_cyc, 2);
      end
      prev_ov = m_out;
    end
  end

  // Stimulus helpers; each is entered and left just after a falling edge.
  task automatic send(input logic [15:0] px, input int gap);
    int  n;
    bit  took;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = px;
    n = 0;
    forever begin
      @(posedge clk);
      took = in_ready && !flush;
      @(negedge clk);
      if (took) break;
      if (++n > 40) begin
        timeout("send");
        break;
      end
    end
  endtask

  task automatic send4(input logic [15:0] a, b, c, d, input int gap);
    send(a, gap);
    send(b, gap);
    send(c, gap);
    send(d, gap);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int  n;
    bit  done;
    n = 0;
    forever begin
      @(posedge clk);
      done = out_valid && out_ready;
      @(negedge clk);
      if (done) break;
      if (++n > 40) begin
        timeout("wait_out");
        break;
      end
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid) begin
      @(negedge clk);
      if (++n > 40) begin
        timeout("wait_valid");
        break;
      end
    end
  endtask

  task automatic chk_last_avg(input string nm, input logic [15:0] exp);
    if (obs_d.size() == 0) timeout(nm);
    else chk(nm, obs_d[obs_d.size()-1], exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"},  out_last, 1'b0);
    chk({tag, "_out_data"},  out_data, 16'd0);
    chk({tag, "_alu_ctrl"},  alu_control, 4'd10);
    chk({tag, "_alu_a"},     alu_a, 16'd0);
    chk({tag, "_alu_b"},     alu_b, 16'd0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int   base;
    logic [6:0] pat;

    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic average and wrap/truncation cases.
    out_ready = 1'b1;
    send4(16'd10, 16'd20, 16'd30, 16'd40, 0);
    wait_out();
    chk_last_avg("avg_basic", 16'd25);
    send4(16'd1, 16'd1, 16'd1, 16'd2, 0);
    wait_out();
    chk_last_avg("avg_trunc", 16'd1);
    send4(16'hFFFF, 16'd1, 16'd0, 16'd0, 0);
    wait_out();
    chk_last_avg("avg_wrap", 16'd0);

    // Gapped input then a stalled consumer; a word offered during the stall
    // must not be taken.
    out_ready = 1'b0;
    send4(16'd10, 16'd20, 16'd30, 16'd40, 1);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 16'd99;
    repeat (5) @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_out();
    chk_last_avg("avg_stall", 16'd25);

    // Flush after two accepts discards the partial group.
    send(16'd7, 0);
    send(16'd8, 0);
    in_valid = 1'b0;
    do_flush();
    send4(16'd4, 16'd4, 16'd4, 16'd4, 0);
    wait_out();
    chk_last_avg("avg_flush", 16'd4);

    // Line marker over seven outputs from a fresh frame.
    do_flush();
    base = obs_l.size();
    for (int i = 0; i < 7; i++) begin
      send4(16'($urandom_range(0, 16383)), 16'($urandom_range(0, 16383)),
            16'($urandom_range(0, 16383)), 16'($urandom_range(0, 16383)), 0);
      wait_out();
    end
    pat = 7'b0100100;
    if (obs_l.size() < base + 7) timeout("line_count");
    else for (int i = 0; i < 7; i++) chk("line_last_pat", obs_l[base+i], pat[i]);

    // Async reset mid-accumulate and mid-output.
    send(16'd5, 0);
    send(16'd6, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst_acc");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send4(16'd8, 16'd8, 16'd8, 16'd8, 0);
    wait_valid();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("rst_out");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    send4(16'd100, 16'd200, 16'd300, 16'd400, 0);
    wait_out();
    chk_last_avg("avg_after_rst", 16'd250);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ds_avg_sequencer.md
Name: ds_avg_sequencer

Overview:
Sequences the shared 16-bit ALU to produce one 2x2 down-sample average from every four pixel words received on a valid/ready input stream. It accumulates with the ALU's load (BtoC) and ADD operations, then divides with DIV (A>>2). The result is presented on a valid/ready output stream, and an end-of-line marker is generated. The block sits between the pixel fetch logic and the result write-back. It owns the ALU control, A and B inputs whenever it is enabled.

Parameters:
WIDTH, 16, datapath width; must match the ALU width.
LINE_LEN, 320, number of outputs per line; out_last is asserted on every LINE_LEN-th output.
LCNT_W, 9, line counter width; must satisfy 2^LCNT_W >= LINE_LEN.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous abort; discards any partial average and any pending output.
in_valid  in  1  pixel word available.
in_ready  out  1  block accepts the pixel word this cycle.
in_data  in  WIDTH  pixel word.
out_valid  out  1  average available.
out_ready  in  1  consumer accepts the average.
out_data  out  WIDTH  average value.
out_last  out  1  qualifies out_data; marks the last output of a line.
alu_control  out  4  ALU opcode.
alu_a  out  WIDTH  ALU operand A.
alu_b  out  WIDTH  ALU operand B.
alu_c  in  WIDTH  ALU result; combinational from the alu_* outputs in the same cycle.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: state=IDLE, acc=0, res=0, tap_cnt=0, line_cnt=0, in_ready=0, out_valid=0, out_last=0, out_data=0, alu_control=AtoC(10), alu_a=0, alu_b=0.
- Reset during any operation returns the block to IDLE immediately. No partial result is emitted.
- States:
  - IDLE: in_ready=1. On an in_valid&in_ready handshake: alu_control=BtoC(11), alu_b=in_data; acc<=alu_c, tap_cnt<=1, go to ACC.
  - ACC: in_ready=1. On handshake: alu_control=ADD(0), alu_a=acc, alu_b=in_data; acc<=alu_c, tap_cnt<=tap_cnt+1. When tap_cnt==3 at the handshake, go to DIV.
  - DIV: in_ready=0. alu_control=DIV(3), alu_a=acc; res<=alu_c, go to OUT. Always takes exactly 1 cycle.
  - OUT: in_ready=0, out_valid=1, out_data=res, out_last=(line_cnt==LINE_LEN-1). On out_ready: line_cnt wraps to 0 if it was LINE_LEN-1, otherwise increments; go to IDLE.
- When no handshake occurs in IDLE or ACC, the ALU drive is alu_control=AtoC(10), alu_a=acc, alu_b=0. The ALU is never left on an undefined opcode.
- in_valid gaps in ACC hold acc and tap_cnt unchanged.
- out_ready low in OUT holds out_data and out_last stable.
- Minimum latency is 6 cycles per output: 4 accepts, DIV, OUT. out_valid rises 2 cycles after the 4th accept. The design does not overlap sequences.
- Arithmetic is modulo 2^WIDTH, inherited from the ALU. The sum wraps before the divide. Producers keep pixels at 14 bits or less for exact averages.
- The Z flag is unused; the block never issues SUB.
- flush takes priority over any handshake in the same cycle. It returns the block to IDLE, clears acc and tap_cnt, and drops out_valid. line_cnt is also cleared, because a flush starts a new frame.
- When flush and rst_n are both active, reset dominates.

Decomposition:
- Shared package ds_pkg:
  - ALU opcode constants ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NOT=6, INC=7, DEC=8, LSHIFT8=9, AtoC=10, BtoC=11.
  - State encoding IDLE/ACC/DIV/OUT.
  - DS_TAPS=4.
- One sub-module, ds_line_counter: a wrapping counter with increment and clear inputs and a terminal flag. It produces out_last and handles the line_cnt wrap.

Test Plan:
- Basic average: inputs 10,20,30,40 back-to-back with out_ready=1 -> ALU opcodes seen BtoC,ADD,ADD,ADD,DIV; out_data=25 with out_valid high 1 cycle; out_valid rises 2 cycles after the 4th accept.
- Truncation and wrap: inputs 1,1,1,2 -> out_data=1. Inputs 0xFFFF,1,0,0 -> sum wraps to 0, out_data=0.
- Flow control: in_valid toggling every other cycle, then out_ready held low 5 cycles -> out_data=25 held stable; in_ready=0 throughout DIV and OUT; the next sequence starts only after out_ready.
- Line marker: LINE_LEN=3, emit 7 averages -> out_last high on outputs 3 and 6 only; line_cnt wraps to 0.
- Flush: flush asserted after 2 accepts -> IDLE next cycle, out_valid stays 0; the next four inputs 4,4,4,4 give out_data=4.
- Async reset: rst_n pulsed low mid-ACC and again mid-OUT -> all outputs at reset values before the next clk edge; no stale output after release.
